// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = 2;

    typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// FIFO-side and downstream-side signals of the drain controller.
interface fifo_drain_ctrl_if #(
    parameter int WORD_SIZE = 6,
    parameter int CNT_W     = 8
);
    logic                 enable;
    logic                 fifo_empty;
    logic                 fifo_almost_empty;
    logic                 fifo_error;
    logic [WORD_SIZE-1:0] fifo_data_out;
    logic                 pause;
    logic                 fifo_rd;
    logic [WORD_SIZE-1:0] data_out;
    logic                 valid_out;
    logic [CNT_W-1:0]     words_out;
    logic                 busy;
    logic                 error;

    modport master (
        input  enable, fifo_empty, fifo_almost_empty, fifo_error, fifo_data_out, pause,
        output fifo_rd, data_out, valid_out, words_out, busy, error
    );

    modport slave (
        output enable, fifo_empty, fifo_almost_empty, fifo_error, fifo_data_out, pause,
        input  fifo_rd, data_out, valid_out, words_out, busy, error
    );
endinterface

// File: rtl/fifo_drain_skid.sv
// Two-entry skid buffer catching words returned by the FIFO one cycle after each pop strobe.
module fifo_drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int WORD_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] head,
    output occ_t                 occ
);

    localparam occ_t FULL = occ_t'(SKID_DEPTH);

    logic [WORD_SIZE-1:0] ent0;
    logic [WORD_SIZE-1:0] ent1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= '0;
        end else begin
            case ({wr, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        ent0 <= wr_data;
                    end else if (occ == 2'd1) begin
                        ent1 <= wr_data;
                    end
                    // A write into a full buffer is dropped; the top flags it as overflow.
                    if (occ != FULL) begin
                        occ <= occ + 2'd1;
                    end
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == FULL) begin
                        ent0 <= ent1;
                        ent1 <= wr_data;
                    end else begin
                        ent0 <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = ent0;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO drain controller: pops the FIFO, absorbs read latency in a skid, delivers on valid/pause.
// Optional FIFO_DRAIN_BURST_EN: start draining only once the FIFO is above its almost-empty threshold.
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int WORD_SIZE = 6,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    fifo_drain_ctrl_if.master bus
);

    localparam occ_t           FULL  = occ_t'(SKID_DEPTH);
    localparam logic [OCC_W:0] DEPTH = (OCC_W+1)'(SKID_DEPTH);

    state_t               state;
    state_t               state_n;
    logic                 rd_q;
    logic                 rd_ok;
    logic                 pop;
    logic                 start_ok;
    logic                 stop_req;
    logic                 stall_exit;
    logic                 overflow;
    occ_t                 occ;
    logic [WORD_SIZE-1:0] head;
    logic [OCC_W:0]       occ_after_pop;
    logic [OCC_W:0]       occ_proj;

    assign pop           = !bus.pause && (occ != '0);
    assign occ_after_pop = {1'b0, occ} - {{OCC_W{1'b0}}, pop};
    assign occ_proj      = occ_after_pop + {{OCC_W{1'b0}}, rd_q};
    assign stop_req      = !bus.enable || bus.fifo_empty;
    assign stall_exit    = !bus.pause && (occ_after_pop < DEPTH);
    assign overflow      = rd_q && (occ == FULL) && !pop;

`ifdef FIFO_DRAIN_BURST_EN
    assign start_ok = bus.enable && !bus.fifo_empty && !bus.fifo_almost_empty;
`else
    logic unused_almost_empty;
    assign unused_almost_empty = bus.fifo_almost_empty;
    assign start_ok            = bus.enable && !bus.fifo_empty;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Reads resume in the same cycle STALL is left, so the refill overlaps the skid
    // draining its two held words and the stream continues without a bubble.
    always_comb begin
        state_n = state;
        rd_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (stop_req) begin
                    state_n = IDLE;
                end else begin
                    rd_ok = 1'b1;
                    if (bus.pause || (occ == FULL)) begin
                        state_n = STALL;
                    end
                end
            end
            STALL: begin
                if (stop_req) begin
                    state_n = IDLE;
                end else if (stall_exit) begin
                    state_n = DRAIN;
                    rd_ok   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.fifo_rd = rd_ok && !bus.fifo_empty && (occ_proj < DEPTH);
    assign bus.busy    = (state == DRAIN) || (state == STALL) || (occ != '0) || rd_q;

    fifo_drain_skid #(
        .WORD_SIZE(WORD_SIZE)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .wr     (rd_q),
        .wr_data(bus.fifo_data_out),
        .pop    (pop),
        .head   (head),
        .occ    (occ)
    );

    // Output stage: one skid word per unpaused cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q          <= 1'b0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.words_out <= '0;
            bus.error     <= 1'b0;
        end else begin
            rd_q          <= bus.fifo_rd;
            bus.valid_out <= pop;
            if (pop) begin
                bus.data_out <= head;
            end
            bus.words_out <= bus.words_out + CNT_W'(pop);
            if (overflow || bus.fifo_error) begin
                bus.error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed and randomized bench for fifo_drain_ctrl against an order-preserving FIFO scoreboard.
module tb_fifo_drain_ctrl;

    localparam int WS = 6;
    localparam int CW = 8;

    logic clk;
    logic reset;

    fifo_drain_ctrl_if #(.WORD_SIZE(WS), .CNT_W(CW)) bus ();

    fifo_drain_ctrl #(.WORD_SIZE(WS), .CNT_W(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // FIFO memory model: data appears on fifo_data_out the cycle after fifo_rd.
    logic [WS-1:0] fmem [0:1023];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd) begin
            bus.fifo_data_out <= fmem[rd_ptr % 1024];
            rd_ptr            <= rd_ptr + 1;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    int            checks    = 0;
    int            errors    = 0;
    int            delivered = 0;
    bit            err_exp   = 1'b0;
    logic [WS-1:0] exp_q [$];

    bit rd_h [0:63];
    bit v_h  [0:63];
    bit b_h  [0:63];
    int first_rd, last_rd, n_rd, first_v, last_v, n_v, nv, pl, gaps;
    bit applied, seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WS-1:0] w);
        fmem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    // One clock: sample #1 after the edge and score the cycle against the FIFO order.
    task automatic step();
        logic pp;
        pp = bus.pause;
        @(posedge clk);
        #1;
        chk("rd_while_empty", 32'(bus.fifo_rd & bus.fifo_empty), 0);
        if (pp) chk("pause_gap", 32'(bus.valid_out), 0);
        if (bus.valid_out) begin
            if (exp_q.size() == 0) chk("extra_word", 32'(bus.valid_out), 0);
            else chk("data", 32'(bus.data_out), 32'(exp_q.pop_front()));
            delivered++;
        end
        chk("words_out", 32'(bus.words_out), delivered % 256);
        chk("error", 32'(bus.error), 32'(err_exp));
    endtask

    task automatic run_until_idle(input int max, input bit rnd);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < max) begin
            if (rnd) bus.pause = ($urandom_range(0, 3) == 0);
            step();
            n++;
        end
        bus.pause = 1'b0;
        chk("drain_done", exp_q.size(), 0);
        chk("drain_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        reset                 = 1'b1;
        bus.enable            = 1'b0;
        bus.pause             = 1'b0;
        bus.fifo_error        = 1'b0;
        bus.fifo_almost_empty = 1'b0;

        // Reset held, FIFO empty, drain disabled.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_fifo_rd", 32'(bus.fifo_rd), 0);
            chk("rst_valid", 32'(bus.valid_out), 0);
            chk("rst_data", 32'(bus.data_out), 0);
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_words", 32'(bus.words_out), 0);
        end
        reset = 1'b0;
        step();

        // Three preloaded words, no back-pressure.
        push(6'h05);
        push(6'h2A);
        push(6'h11);
        bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            rd_h[i] = bus.fifo_rd;
            v_h[i]  = bus.valid_out;
            b_h[i]  = bus.busy;
        end
        first_rd = -1; last_rd = -1; n_rd = 0;
        first_v  = -1; last_v  = -1; n_v  = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd_h[i]) begin
                if (first_rd < 0) first_rd = i;
                last_rd = i;
                n_rd++;
            end
            if (v_h[i]) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                n_v++;
            end
        end
        chk("t2_rd_count", n_rd, 3);
        chk("t2_rd_consec", last_rd - first_rd, 2);
        chk("t2_vld_count", n_v, 3);
        chk("t2_vld_consec", last_v - first_v, 2);
        chk("t2_latency", first_v - first_rd, 3);
        chk("t2_words", 32'(bus.words_out), 3);
        if (n_v > 0) begin
            chk("t2_busy_last", 32'(b_h[last_v]), 0);
            chk("t2_busy_before", 32'(b_h[last_v - 1]), 1);
        end
        chk("t2_all_out", exp_q.size(), 0);

        // Ten-word stream with a three-cycle pause after the third delivery.
        for (int i = 0; i < 10; i++) push(6'($urandom_range(0, 63)));
        nv = 0; pl = 0; applied = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            v_h[i] = bus.valid_out;
            if (bus.valid_out) nv++;
            if (pl > 0) begin
                pl--;
                if (pl == 0) bus.pause = 1'b0;
            end else if (nv == 3 && !applied) begin
                applied   = 1'b1;
                bus.pause = 1'b1;
                pl        = 3;
            end
        end
        first_v = -1; last_v = -1; gaps = 0;
        for (int i = 0; i < 40; i++) begin
            if (v_h[i]) begin
                if (first_v < 0) first_v = i;
                last_v = i;
            end
        end
        for (int i = 0; i < 40; i++) begin
            if (i > first_v && i < last_v && !v_h[i]) gaps++;
        end
        chk("t3_count", nv, 10);
        chk("t3_gap", gaps, 3);
        run_until_idle(20, 1'b0);

        // FIFO empties mid-burst: the in-flight word must still arrive.
        push(6'h3C);
        push(6'h07);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!seen && bus.fifo_empty && exp_q.size() != 0) begin
                seen = 1'b1;
                chk("t4_empty_rd", 32'(bus.fifo_rd), 0);
                chk("t4_empty_busy", 32'(bus.busy), 1);
            end
        end
        chk("t4_seen_empty", 32'(seen), 1);
        run_until_idle(20, 1'b0);

        // Enable dropped mid-burst: in-flight words finish, the rest stay queued.
        for (int i = 0; i < 6; i++) push(6'(i * 9 + 1));
        nv = 0;
        for (int i = 0; i < 20 && nv < 2; i++) begin
            step();
            if (bus.valid_out) nv++;
        end
        bus.enable = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("en_low_rd", 32'(bus.fifo_rd), 0);
        end
        chk("en_low_busy", 32'(bus.busy), 0);
        chk("en_low_rem", exp_q.size(), wr_ptr - rd_ptr);
        bus.enable = 1'b1;
        run_until_idle(40, 1'b0);

        // Sticky error from a one-cycle fifo_error pulse.
        bus.fifo_error = 1'b1;
        err_exp        = 1'b1;
        step();
        bus.fifo_error = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", 32'(bus.error), 1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 8; i++) push(6'($urandom_range(0, 63)));
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.valid_out), 0);
        chk("mid_rst_words", 32'(bus.words_out), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_error", 32'(bus.error), 0);
        chk("mid_rst_data", 32'(bus.data_out), 0);
        bus.enable = 1'b0;
        wr_ptr     = rd_ptr;
        exp_q.delete();
        delivered  = 0;
        err_exp    = 1'b0;
        step();
        step();
        reset      = 1'b0;
        bus.enable = 1'b1;
        step();

        // Randomized traffic with random pauses, driving the counter through its wrap.
        for (int i = 0; i < 255; i++) push(6'($urandom_range(0, 63)));
        run_until_idle(3000, 1'b1);
        chk("wrap_ff", 32'(bus.words_out), 32'hFF);
        push(6'h2B);
        run_until_idle(20, 1'b0);
        chk("wrap_00", 32'(bus.words_out), 0);

`ifdef FIFO_DRAIN_BURST_EN
        push(6'h15);
        bus.fifo_almost_empty = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("burst_hold_rd", 32'(bus.fifo_rd), 0);
        end
        bus.fifo_almost_empty = 1'b0;
        run_until_idle(20, 1'b0);
`else
        push(6'h15);
        bus.fifo_almost_empty = 1'b1;
        run_until_idle(20, 1'b0);
        bus.fifo_almost_empty = 1'b0;
`endif
        chk("final_words", 32'(bus.words_out), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
